snake_stepper: RTL and testbench

Game-side consumer of the rate divider tick. On every `enable` pulse it advances the snake head one grid cell in the current direction, applying queued player turns. It detects wall collisions and owns the game speed: it drives `max_ticks`/`par_load` back into the rate divider, shortening the tick period each time food is eaten.

---
 rtl/snake_stepper.sv | 219 +++++++++++++++++++++
 tb/tb_snake_stepper.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_stepper.sv
// Snake head stepper: advances the head on each rate-divider tick, queues player turns,
// detects wall hits and shortens the tick period on food. STEPPER_WRAP_EN selects wrap-around walls.
module snake_stepper #(
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned START_X    = 20,
  parameter int unsigned START_Y    = 15,
  parameter logic [27:0] INIT_TICKS = 28'd12_499_999,
  parameter logic [27:0] MIN_TICKS  = 28'd2_499_999,
  parameter logic [27:0] SPEEDUP    = 28'd500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dir_valid,
  input  logic [1:0]  dir_req,
  input  logic        grow,
  output logic [5:0]  head_x,
  output logic [5:0]  head_y,
  output logic [1:0]  dir,
  output logic        step,
  output logic        collide,
  output logic [27:0] max_ticks,
  output logic        par_load
);

  localparam int unsigned COORD_W = 6;
  localparam int unsigned TICK_W  = 28;
  localparam int unsigned DIR_W   = 2;
  localparam int unsigned CNT_W   = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b11;

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);

  // Below this period a full SPEEDUP would undershoot (or underflow), so clamp instead.
  localparam logic [TICK_W:0] SPEED_FLOOR = (TICK_W+1)'(MIN_TICKS) + (TICK_W+1)'(SPEEDUP);

`ifdef STEPPER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DIR_W-1:0]   fifo_q [2];
  logic [DIR_W-1:0]   fifo_d [2];
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d, cnt_pop;
  logic               load_pend_q, load_pend_d;

  logic [COORD_W-1:0] head_x_d, head_y_d;
  logic [DIR_W-1:0]   dir_d;
  logic               step_d, collide_d, par_load_d;
  logic [TICK_W-1:0]  max_ticks_d;

  logic [DIR_W-1:0]   ref_dir, step_dir;
  logic               pop, push;
  logic [COORD_W-1:0] nx, ny;
  logic               wall, dead_hit;

  // Turn queue decisions, all taken against the contents before this cycle's update.
  always_comb begin
    ref_dir = dir;
    if (fifo_cnt_q == CNT_W'(2))      ref_dir = fifo_q[1];
    else if (fifo_cnt_q == CNT_W'(1)) ref_dir = fifo_q[0];
    pop      = enable && (fifo_cnt_q != CNT_W'(0));
    step_dir = pop ? fifo_q[0] : dir;
    push     = dir_valid
            && (dir_req != ref_dir)
            && (dir_req != (ref_dir ^ 2'b10))
            && ((fifo_cnt_q != CNT_W'(2)) || pop);
  end

  // Next cell in the step direction; nx/ny already hold the wrapped cell on a wall exit.
  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    case (step_dir)
      DIR_UP: begin
        if (head_y == COORD_W'(0)) begin
          wall = 1'b1;
          ny   = Y_MAX;
        end else begin
          ny = head_y - COORD_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin
          wall = 1'b1;
          nx   = COORD_W'(0);
        end else begin
          nx = head_x + COORD_W'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
          wall = 1'b1;
          ny   = COORD_W'(0);
        end else begin
          ny = head_y + COORD_W'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x == COORD_W'(0)) begin
          wall = 1'b1;
          nx   = X_MAX;
        end else begin
          nx = head_x - COORD_W'(1);
        end
      end
      default: ;
    endcase
    dead_hit = wall && !WRAP_EN;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    fifo_d[0]   = fifo_q[0];
    fifo_d[1]   = fifo_q[1];
    fifo_cnt_d  = fifo_cnt_q;
    cnt_pop     = fifo_cnt_q;
    load_pend_d = 1'b0;
    head_x_d    = head_x;
    head_y_d    = head_y;
    dir_d       = dir;
    step_d      = 1'b0;
    collide_d   = collide;
    max_ticks_d = max_ticks;
    par_load_d  = load_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (dir_valid) begin
          dir_d   = dir_req;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (pop) fifo_d[0] = fifo_q[1];
        cnt_pop = fifo_cnt_q - CNT_W'(pop);
        if (push) begin
          if (cnt_pop == CNT_W'(0)) fifo_d[0] = dir_req;
          else                      fifo_d[1] = dir_req;
        end
        fifo_cnt_d = cnt_pop + CNT_W'(push);

        if (enable) begin
          dir_d = step_dir;
          if (dead_hit) begin
            state_d   = ST_DEAD;
            collide_d = 1'b1;
          end else begin
            head_x_d = nx;
            head_y_d = ny;
            step_d   = 1'b1;
          end
        end

        // A grow on the collision edge is discarded.
        if (grow && !(enable && dead_hit)) begin
          if ({1'b0, max_ticks} < SPEED_FLOOR) max_ticks_d = MIN_TICKS;
          else                                 max_ticks_d = max_ticks - SPEEDUP;
          load_pend_d = 1'b1;
        end
      end

      ST_DEAD: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fifo_q[0]   <= DIR_UP;
      fifo_q[1]   <= DIR_UP;
      fifo_cnt_q  <= CNT_W'(0);
      load_pend_q <= 1'b0;
      head_x      <= X_START;
      head_y      <= Y_START;
      dir         <= DIR_RIGHT;
      step        <= 1'b0;
      collide     <= 1'b0;
      max_ticks   <= INIT_TICKS;
      par_load    <= 1'b1;
    end else begin
      state_q     <= state_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      fifo_cnt_q  <= fifo_cnt_d;
      load_pend_q <= load_pend_d;
      head_x      <= head_x_d;
      head_y      <= head_y_d;
      dir         <= dir_d;
      step        <= step_d;
      collide     <= collide_d;
      max_ticks   <= max_ticks_d;
      par_load    <= par_load_d;
    end
  end

endmodule

// File: tb/tb_snake_stepper.sv
// Self-checking bench for snake_stepper: directed vector table, hand-written corner
// sequences and a randomized run, all against a queue-based behavioural model.
module tb_snake_stepper;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int INIT_T = 12_499_999;
  localparam int MIN_T  = 2_499_999;
  localparam int SPD    = 500_000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        dir_valid = 1'b0;
  logic [1:0]  dir_req = 2'b00;
  logic        grow = 1'b0;
  logic [5:0]  head_x, head_y;
  logic [1:0]  dir;
  logic        step, collide, par_load;
  logic [27:0] max_ticks;

  int total = 0;
  int bad = 0;

  snake_stepper dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_valid(dir_valid),
    .dir_req(dir_req), .grow(grow), .head_x(head_x), .head_y(head_y),
    .dir(dir), .step(step), .collide(collide), .max_ticks(max_ticks),
    .par_load(par_load)
  );

  always #5 clk = ~clk;

  // Behavioural model: coordinates as ints, turn queue as a SV queue.
  int         mx, my, mticks, mstate; // mstate: 0 idle, 1 running, 2 dead
  logic [1:0] mdir;
  logic [1:0] mq[$];
  bit         mstep, mcol, mpar, mpend;

  task automatic model_reset();
    mx = 20; my = 15; mdir = 2'b01; mticks = INIT_T; mstate = 0;
    mq.delete(); mstep = 0; mcol = 0; mpar = 1; mpend = 0;
  endtask

  task automatic model_step(bit en, bit dv, logic [1:0] dr, bit gr);
    logic [1:0] refd, d;
    bit popping, accept, dead, newpar;
    int tx, ty;
    newpar = mpend;
    mpend  = 0;
    mstep  = 0;
    dead   = 0;
    if (mstate == 0) begin
      if (dv) begin mdir = dr; mstate = 1; end
    end else if (mstate == 1) begin
      refd    = (mq.size() > 0) ? mq[mq.size()-1] : mdir;
      popping = en && (mq.size() > 0);
      d       = popping ? mq[0] : mdir;
      accept  = dv && (dr != refd) && (dr != (refd ^ 2'b10)) && (mq.size() < 2 || popping);
      if (popping) void'(mq.pop_front());
      if (accept) mq.push_back(dr);
      if (en) begin
        mdir = d;
        tx = mx; ty = my;
        case (d)
          2'b00: ty = my - 1;
          2'b01: tx = mx + 1;
          2'b10: ty = my + 1;
          default: tx = mx - 1;
        endcase
        if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) begin
`ifdef STEPPER_WRAP_EN
          tx = (tx + GW) % GW;
          ty = (ty + GH) % GH;
          mx = tx; my = ty; mstep = 1;
`else
          dead = 1; mstate = 2; mcol = 1;
`endif
        end else begin
          mx = tx; my = ty; mstep = 1;
        end
      end
      if (gr && !dead) begin
        mticks = (mticks - SPD < MIN_T) ? MIN_T : mticks - SPD;
        mpend  = 1;
      end
    end
    mpar = newpar;
  endtask

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".head_x"}, head_x, mx);
    chk({tag, ".head_y"}, head_y, my);
    chk({tag, ".dir"}, dir, mdir);
    chk({tag, ".step"}, step, mstep);
    chk({tag, ".collide"}, collide, mcol);
    chk({tag, ".max_ticks"}, max_ticks, mticks);
    chk({tag, ".par_load"}, par_load, mpar);
  endtask

  // Entered and left just after a falling edge.
  task automatic cycle(bit en, bit dv, logic [1:0] dr, bit gr);
    enable = en; dir_valid = dv; dir_req = dr; grow = gr;
    @(posedge clk);
    model_step(en, dv, dr, gr);
    #1 check_all("cyc");
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 0; dir_valid = 0; dir_req = 0; grow = 0;
    reset = 1;
    model_reset();
    #1 check_all("rst");
    @(negedge clk);
    reset = 0;
    #1 check_all("rst_rel");
  endtask

  typedef struct {
    bit en; bit dv; logic [1:0] dr; bit gr;
    int ex; int ey; logic [1:0] edir; bit estep;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{1, 0, 2'b00, 0, 20, 15, 2'b01, 0};
    vt[1]  = '{1, 0, 2'b00, 0, 20, 15, 2'b01, 0};
    vt[2]  = '{1, 0, 2'b00, 0, 20, 15, 2'b01, 0};
    vt[3]  = '{0, 1, 2'b01, 0, 20, 15, 2'b01, 0};
    vt[4]  = '{1, 0, 2'b00, 0, 21, 15, 2'b01, 1};
    vt[5]  = '{1, 0, 2'b00, 0, 22, 15, 2'b01, 1};
    vt[6]  = '{1, 0, 2'b00, 0, 23, 15, 2'b01, 1};
    vt[7]  = '{1, 0, 2'b00, 0, 24, 15, 2'b01, 1};
    vt[8]  = '{1, 0, 2'b00, 0, 25, 15, 2'b01, 1};
    vt[9]  = '{0, 0, 2'b00, 0, 25, 15, 2'b01, 0};
    vt[10] = '{0, 1, 2'b11, 0, 25, 15, 2'b01, 0};
    vt[11] = '{0, 1, 2'b00, 0, 25, 15, 2'b01, 0};
    vt[12] = '{0, 1, 2'b10, 0, 25, 15, 2'b01, 0};
    vt[13] = '{1, 0, 2'b00, 0, 25, 14, 2'b00, 1};
    vt[14] = '{1, 0, 2'b00, 0, 25, 13, 2'b00, 1};
    vt[15] = '{1, 1, 2'b01, 0, 25, 12, 2'b00, 1};
    vt[16] = '{1, 0, 2'b00, 0, 26, 12, 2'b01, 1};

    @(negedge clk);
    do_reset();
    chk("post_reset_par_load", par_load, 1);
    chk("post_reset_max_ticks", max_ticks, INIT_T);

    // Directed table: idle ticks, start, straight run, turn filtering, same-cycle push/pop.
    for (int i = 0; i < 17; i++) begin
      cycle(vt[i].en, vt[i].dv, vt[i].dr, vt[i].gr);
      chk($sformatf("vec%0d.x", i), head_x, vt[i].ex);
      chk($sformatf("vec%0d.y", i), head_y, vt[i].ey);
      chk($sformatf("vec%0d.dir", i), dir, vt[i].edir);
      chk($sformatf("vec%0d.step", i), step, vt[i].estep);
      if (i == 0) chk("vec0.par_load_cleared", par_load, 0);
    end

    // Right wall: 19 moves reach x=39, the 20th collides (or wraps).
    do_reset();
    cycle(0, 1, 2'b01, 0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1, 0, 2'b00, 0);
      if (i == 19) chk("wall.x39", head_x, 39);
    end
`ifdef STEPPER_WRAP_EN
    chk("wrap.x0", head_x, 0);
    chk("wrap.collide", collide, 0);
`else
    chk("wall.collide", collide, 1);
    chk("wall.step", step, 0);
    chk("wall.x_hold", head_x, 39);
    chk("wall.y_hold", head_y, 15);
    cycle(1, 1, 2'b00, 1);
    cycle(1, 0, 2'b00, 0);
    chk("dead.x_hold", head_x, 39);
    chk("dead.ticks_hold", max_ticks, INIT_T);
`endif

    // Asynchronous reset in the middle of the high phase.
    enable = 0; dir_valid = 0; grow = 0;
    @(posedge clk);
    model_step(0, 0, 2'b00, 0);
    #2 reset = 1;
    #1;
    chk("async.collide", collide, 0);
    chk("async.x", head_x, 20);
    chk("async.y", head_y, 15);
    chk("async.par_load", par_load, 1);
    model_reset();
    check_all("async");
    @(negedge clk);
    reset = 0;
    cycle(1, 0, 2'b00, 0);
    chk("async.idle_x", head_x, 20);

    // Speed-up: 21 grows, saturating at the floor from the 20th on.
    do_reset();
    cycle(0, 1, 2'b01, 0);
    for (int k = 1; k <= 21; k++) begin
      int expt;
      expt = INIT_T - k * SPD;
      if (expt < MIN_T) expt = MIN_T;
      cycle(0, 0, 2'b00, 1);
      chk($sformatf("grow%0d.ticks", k), max_ticks, expt);
      chk($sformatf("grow%0d.par_early", k), par_load, 0);
      cycle(0, 0, 2'b00, 0);
      chk($sformatf("grow%0d.par_load", k), par_load, 1);
    end
    cycle(0, 0, 2'b00, 0);
    chk("grow.par_clear", par_load, 0);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
